// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered pop data, async active-high reset.
// Optional sticky overflow/underflow outputs when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_read_data;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  assign w_full  = (r_count == LP_FULL);
  assign w_empty = (r_count == '0);

  // A read frees a slot in the same edge, so a full FIFO may still accept a write.
  assign w_wr_en = write && (!w_full || read);
  assign w_rd_en = read && !w_empty;

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign read_data = r_read_data;

  // Storage array: not reset, writes blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  // Write pointer advances on every accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer and registered pop data; data holds when no pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_read_data <= '0;
    end else if (w_rd_en) begin
      r_rd_ptr    <= r_rd_ptr + AW'(1);
      r_read_data <= r_mem[r_rd_ptr];
    end
  end

  // Occupancy tracks push-only and pop-only cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write && w_full && !read) begin
        r_overflow <= 1'b1;
      end
      if (read && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test of sync_fifo (DATA_WIDTH=8, DEPTH=8).
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       read;
  logic       write;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .write(write),
    .write_data(write_data),
    .read_data(read_data),
    .full(full),
    .empty(empty),
    .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    write_data = 8'h00;
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rdata", 32'(read_data), 32'h00);
    reset = 1'b0;

    // three pushes
    write = 1'b1;
    write_data = 8'h55; tick();
    write_data = 8'hAA; tick();
    write_data = 8'hF0; tick();
    write = 1'b0;
    check("w3_count", 32'(count), 32'd3);
    check("w3_empty", 32'(empty), 32'd0);
    check("w3_full", 32'(full), 32'd0);

    // two pops
    read = 1'b1;
    tick();
    check("r1_data", 32'(read_data), 32'h55);
    tick();
    check("r2_data", 32'(read_data), 32'hAA);
    read = 1'b0;
    check("r2_count", 32'(count), 32'd1);

    // simultaneous read/write with count=1
    read = 1'b1; write = 1'b1; write_data = 8'h0F;
    tick();
    check("rw_data", 32'(read_data), 32'hF0);
    check("rw_count", 32'(count), 32'd1);
    write = 1'b0;
    tick();
    check("rw_next", 32'(read_data), 32'h0F);
    check("rw_empty", 32'(empty), 32'd1);
    read = 1'b0;

    // read on empty after reset
    pulse_reset();
    check("re_rst_rd", 32'(read_data), 32'h00);
    read = 1'b1;
    tick();
    read = 1'b0;
    check("re_rdata", 32'(read_data), 32'h00);
    check("re_count", 32'(count), 32'd0);
    check("re_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("re_under", 32'(underflow), 32'd1);
    check("re_over", 32'(overflow), 32'd0);
`endif

    // empty read+write does the write only
    pulse_reset();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("rst_under", 32'(underflow), 32'd0);
`endif
    read = 1'b1; write = 1'b1; write_data = 8'h3C;
    tick();
    read = 1'b0; write = 1'b0;
    check("erw_count", 32'(count), 32'd1);
    check("erw_rdata", 32'(read_data), 32'h00);
    pulse_reset();

    // fill to full, ninth write dropped
    write = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write_data = 8'(i);
      tick();
      if (i == 6) check("pre_full", 32'(full), 32'd0);
      if (i == 7) check("full_8", 32'(full), 32'd1);
    end
    write = 1'b0;
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("ovf_flag", 32'(overflow), 32'd1);
`endif

    // full read+write keeps count at DEPTH
    read = 1'b1; write = 1'b1; write_data = 8'hA5;
    tick();
    write = 1'b0;
    check("frw_data", 32'(read_data), 32'h00);
    check("frw_count", 32'(count), 32'd8);
    check("frw_full", 32'(full), 32'd1);

    // drain: 0x01..0x07 then 0xA5
    for (int i = 1; i < 9; i++) begin
      tick();
      check("drain", 32'(read_data), (i == 8) ? 32'hA5 : 32'(i));
    end
    read = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // wrap: one preloaded word, then 20 push+pop cycles
    write = 1'b1; write_data = 8'h80;
    tick();
    read = 1'b1;
    for (int k = 0; k < 20; k++) begin
      write_data = 8'(8'h81 + k);
      tick();
      check("wrap_data", 32'(read_data), 32'(8'h80 + k));
      check("wrap_count", 32'(count), 32'd1);
    end
    read = 1'b0;

    // grow to five, then async reset between edges
    write_data = 8'hE0;
    for (int j = 0; j < 4; j++) tick();
    write = 1'b0;
    check("pre_ar_count", 32'(count), 32'd5);
    #3;
    reset = 1'b1;
    #1;
    check("ar_count", 32'(count), 32'd0);
    check("ar_empty", 32'(empty), 32'd1);
    check("ar_full", 32'(full), 32'd0);
    check("ar_rdata", 32'(read_data), 32'h00);

    // requests ignored while reset held
    write = 1'b1; read = 1'b1; write_data = 8'h77;
    tick();
    check("inrst_count", 32'(count), 32'd0);
    check("inrst_rdata", 32'(read_data), 32'h00);
    write = 1'b0; read = 1'b0;
    reset = 1'b0;
    tick();
    check("post_count", 32'(count), 32'd0);
    check("post_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
